// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/halfword/word load-store unit in front of the 256x8
// big-endian DMEM. Sub-word stores are done as read-modify-write on the
// containing word; loads extract the addressed lane and extend it.
module dmem_lsu #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              dm_memread,
    output logic              dm_memwrite,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_writedata,
    input  logic [DATA_W-1:0] dm_readdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t              state;
    state_t              next_state;
    logic                we_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   line_q;
    logic [DATA_W-1:0]   load_val;
    logic [DATA_W-1:0]   store_val;
    logic [7:0]          lane8;
    logic [15:0]         lane16;
    logic                illegal;
    logic                accept;

    assign accept  = (state == S_IDLE) && req;
    assign illegal = (size == 2'b11) ||
                     ((size == SZ_HALF) && addr[0]) ||
                     ((size == SZ_WORD) && (addr[1:0] != 2'b00));

    // Control state, error flag and load result; all cleared by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                err <= illegal;
            end
            if ((state == S_RD) && !we_q) begin
                rdata <= load_val;
            end
        end
    end

    // Request fields and the line buffer only matter once a request is held
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
        if (state == S_RD) begin
            line_q <= dm_readdata;
        end
    end

    // Pick the addressed big-endian lane out of the word DMEM returns and extend it
    always_comb begin
        lane8    = 8'h00;
        lane16   = 16'h0000;
        load_val = dm_readdata;
        case (addr_q[1:0])
            2'd0:    lane8 = dm_readdata[31:24];
            2'd1:    lane8 = dm_readdata[23:16];
            2'd2:    lane8 = dm_readdata[15:8];
            default: lane8 = dm_readdata[7:0];
        endcase
        lane16 = addr_q[1] ? dm_readdata[15:0] : dm_readdata[31:16];
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & lane8[7]}}, lane8};
            SZ_HALF: load_val = {{16{sext_q & lane16[15]}}, lane16};
            default: load_val = dm_readdata;
        endcase
    end

    // Merge the store data into the buffered word; a word store bypasses the buffer
    always_comb begin
        store_val = line_q;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    store_val[31:24] = wdata_q[7:0];
                    2'd1:    store_val[23:16] = wdata_q[7:0];
                    2'd2:    store_val[15:8]  = wdata_q[7:0];
                    default: store_val[7:0]   = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1]) begin
                    store_val[15:0] = wdata_q[15:0];
                end else begin
                    store_val[31:16] = wdata_q[15:0];
                end
            end
            default: store_val = wdata_q;
        endcase
    end

    // Next-state logic and the DMEM/handshake outputs decoded from state
    always_comb begin
        next_state   = state;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        dm_memread   = 1'b0;
        dm_memwrite  = 1'b0;
        dm_address   = '0;
        dm_writedata = '0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (illegal) begin
                        next_state = S_DONE;
                    end else if (we && (size == SZ_WORD)) begin
                        next_state = S_WR;
                    end else begin
                        next_state = S_RD;
                    end
                end
            end
            S_RD: begin
                dm_memread = 1'b1;
                dm_address = {addr_q[ADDR_W-1:2], 2'b00};
                next_state = we_q ? S_WR : S_DONE;
            end
            S_WR: begin
                dm_memwrite  = 1'b1;
                dm_address   = {addr_q[ADDR_W-1:2], 2'b00};
                dm_writedata = store_val;
                next_state   = S_DONE;
            end
            default: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a behavioural 256x8
// big-endian DMEM (combinational read, clocked write, no reset).
module tb_dmem_lsu;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        dm_memread;
    logic        dm_memwrite;
    logic [7:0]  dm_address;
    logic [31:0] dm_writedata;
    logic [31:0] dm_readdata;

    logic [7:0]  mem [256];
    int          rd_cnt;
    int          wr_cnt;
    int          both_cnt;
    int          checks;
    int          failures;

    dmem_lsu #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .we           (we),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .dm_memread   (dm_memread),
        .dm_memwrite  (dm_memwrite),
        .dm_address   (dm_address),
        .dm_writedata (dm_writedata),
        .dm_readdata  (dm_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_readdata = {mem[dm_address], mem[dm_address + 8'd1],
                          mem[dm_address + 8'd2], mem[dm_address + 8'd3]};

    // DMEM write port plus counters of memory cycles
    always @(posedge clk) begin
        if (dm_memwrite) begin
            mem[dm_address]        <= dm_writedata[31:24];
            mem[dm_address + 8'd1] <= dm_writedata[23:16];
            mem[dm_address + 8'd2] <= dm_writedata[15:8];
            mem[dm_address + 8'd3] <= dm_writedata[7:0];
            wr_cnt <= wr_cnt + 1;
        end
        if (dm_memread) begin
            rd_cnt <= rd_cnt + 1;
        end
        if (dm_memread && dm_memwrite) begin
            both_cnt <= both_cnt + 1;
        end
    end

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    task automatic set_word(input logic [7:0] a, input logic [31:0] v);
        @(negedge clk);
        mem[a]        = v[31:24];
        mem[a + 8'd1] = v[23:16];
        mem[a + 8'd2] = v[15:8];
        mem[a + 8'd3] = v[7:0];
    endtask

    task automatic run_op(input logic op_we, input logic [1:0] op_size,
                          input logic op_sext, input logic [7:0] op_addr,
                          input logic [31:0] op_wdata,
                          output int lat, output logic e, output logic [31:0] r,
                          output int nrd, output int nwr, output logic done_after);
        int rd0;
        int wr0;
        @(negedge clk);
        rd0      = rd_cnt;
        wr0      = wr_cnt;
        req      = 1'b1;
        we       = op_we;
        size     = op_size;
        sign_ext = op_sext;
        addr     = op_addr;
        wdata    = op_wdata;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e   = err;
        r   = rdata;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        size     = 2'b00;
        sign_ext = 1'b0;
        addr     = 8'h00;
        wdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: busy/done/err=%b expected 000", {busy, done, err});
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        checks++;
        if ({dm_memread, dm_memwrite, dm_address} !== 10'h0) begin
            failures++;
            $display("[TB] FAIL reset_dm: rd=%b wr=%b addr=%h expected all 0",
                     dm_memread, dm_memwrite, dm_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_word_store_load();
        int lat, nrd, nwr;
        logic e, da;
        logic [31:0] r;
        run_op(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, lat, e, r, nrd, nwr, da);
        checks++;
        if (lat !== 2 || nrd !== 0 || nwr !== 1 || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word_store_seq: lat=%0d rd=%0d wr=%0d err=%b expected 2 0 1 0",
                     lat, nrd, nwr, e);
        end
        checks++;
        if (mem_word(8'h10) !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL word_store_mem: got %h expected deadbeef", mem_word(8'h10));
        end
        checks++;
        if (da !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_pulse: done=%b busy=%b one cycle later, expected 0 0", da, busy);
        end
        run_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, lat, e, r, nrd, nwr, da);
        checks++;
        if (r !== 32'hDEADBEEF || e !== 1'b0 || lat !== 2 || nrd !== 1 || nwr !== 0) begin
            failures++;
            $display("[TB] FAIL word_load: rdata=%h err=%b lat=%0d rd=%0d wr=%0d expected deadbeef 0 2 1 0",
                     r, e, lat, nrd, nwr);
        end
    endtask

    task automatic test_subword_store();
        int lat, nrd, nwr;
        logic e, da;
        logic [31:0] r;
        set_word(8'h20, 32'h11223344);
        run_op(1'b1, 2'b00, 1'b0, 8'h22, 32'h000000AB, lat, e, r, nrd, nwr, da);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1 || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL byte_rmw_seq: lat=%0d rd=%0d wr=%0d err=%b expected 3 1 1 0",
                     lat, nrd, nwr, e);
        end
        checks++;
        if (mem_word(8'h20) !== 32'h1122AB44) begin
            failures++;
            $display("[TB] FAIL byte_rmw_mem: got %h expected 1122ab44", mem_word(8'h20));
        end
        run_op(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e, r, nrd, nwr, da);
        checks++;
        if (r !== 32'h1122AB44) begin
            failures++;
            $display("[TB] FAIL byte_rmw_load: got %h expected 1122ab44", r);
        end
        run_op(1'b1, 2'b01, 1'b0, 8'h20, 32'h1234CAFE, lat, e, r, nrd, nwr, da);
        checks++;
        if (mem_word(8'h20) !== 32'hCAFEAB44 || lat !== 3) begin
            failures++;
            $display("[TB] FAIL half_rmw: mem=%h lat=%0d expected cafeab44 3", mem_word(8'h20), lat);
        end
        run_op(1'b1, 2'b00, 1'b0, 8'h23, 32'hFFFFFF5A, lat, e, r, nrd, nwr, da);
        checks++;
        if (mem_word(8'h20) !== 32'hCAFEAB5A) begin
            failures++;
            $display("[TB] FAIL byte3_rmw: mem=%h expected cafeab5a", mem_word(8'h20));
        end
    endtask

    task automatic test_extension();
        int lat, nrd, nwr;
        logic e, da;
        logic [31:0] r;
        logic [1:0]  v_size [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        logic        v_sext [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0]  v_addr [6] = '{8'h31, 8'h32, 8'h30, 8'h30, 8'h30, 8'h32};
        logic [31:0] v_exp  [6] = '{32'hFFFFFFFF, 32'h0000007F, 32'h000080FF,
                                    32'hFFFF80FF, 32'h00000080, 32'h00007F01};
        set_word(8'h30, 32'h80FF7F01);
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, v_size[i], v_sext[i], v_addr[i], 32'h0, lat, e, r, nrd, nwr, da);
            checks++;
            if (r !== v_exp[i] || e !== 1'b0 || lat !== 2) begin
                failures++;
                $display("[TB] FAIL extend_%0d: rdata=%h err=%b lat=%0d expected %h 0 2",
                         i, r, e, lat, v_exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int lat, nrd, nwr;
        logic e, da;
        logic [31:0] r;
        logic        v_we   [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  v_size [3] = '{2'b10, 2'b01, 2'b11};
        logic [7:0]  v_addr [3] = '{8'h13, 8'h41, 8'h00};
        for (int i = 0; i < 3; i++) begin
            run_op(v_we[i], v_size[i], 1'b0, v_addr[i], 32'h55AA55AA, lat, e, r, nrd, nwr, da);
            checks++;
            if (e !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
                failures++;
                $display("[TB] FAIL illegal_%0d: err=%b lat=%0d rd=%0d wr=%0d expected 1 1 0 0",
                         i, e, lat, nrd, nwr);
            end
        end
        checks++;
        if (mem_word(8'h10) !== 32'hDEADBEEF || mem_word(8'h00) !== 32'h0) begin
            failures++;
            $display("[TB] FAIL illegal_mem: [10]=%h [00]=%h expected deadbeef 00000000",
                     mem_word(8'h10), mem_word(8'h00));
        end
        run_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, lat, e, r, nrd, nwr, da);
        checks++;
        if (e !== 1'b0 || r !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL err_clear: err=%b rdata=%h expected 0 deadbeef", e, r);
        end
    endtask

    task automatic test_back_to_back();
        int rd0, wr0, lat;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
        addr = 8'hFC; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        @(negedge clk);
        addr = 8'h40; wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first_done: done=%b busy=%b expected 1 1", done, busy);
        end
        @(negedge clk);
        we = 1'b0; addr = 8'hFC;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_gap: busy=%b done=%b expected 0 0", busy, done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_accept: busy=%b expected 1", busy);
        end
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rdata !== 32'h12345678 || lat !== 2) begin
            failures++;
            $display("[TB] FAIL top_addr_load: rdata=%h lat=%0d expected 12345678 2", rdata, lat);
        end
        checks++;
        if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 1 || mem_word(8'h40) !== 32'h0 ||
            mem_word(8'hFC) !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL b2b_mem: wr=%0d rd=%0d [40]=%h [fc]=%h expected 1 1 00000000 12345678",
                     wr_cnt - wr0, rd_cnt - rd0, mem_word(8'h40), mem_word(8'hFC));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int wr0, lat, nrd, nwr;
        logic e, da;
        logic [31:0] r;
        set_word(8'h50, 32'hA1B2C3D4);
        wr0 = wr_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0;
        addr = 8'h51; wdata = 32'h00000077;
        @(posedge clk);
        #1;
        req = 1'b0;
        checks++;
        if (dm_memread !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_in_rd: dm_memread=%b expected 1", dm_memread);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dm_memwrite !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset: busy=%b done=%b memwrite=%b rdata=%h expected 0 0 0 00000000",
                     busy, done, dm_memwrite, rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_cnt !== wr0 || mem_word(8'h50) !== 32'hA1B2C3D4) begin
            failures++;
            $display("[TB] FAIL mid_mem: writes=%0d [50]=%h expected 0 a1b2c3d4",
                     wr_cnt - wr0, mem_word(8'h50));
        end
        run_op(1'b1, 2'b00, 1'b0, 8'h51, 32'h00000077, lat, e, r, nrd, nwr, da);
        checks++;
        if (lat !== 3 || e !== 1'b0 || mem_word(8'h50) !== 32'hA177C3D4) begin
            failures++;
            $display("[TB] FAIL mid_recover: lat=%0d err=%b [50]=%h expected 3 0 a177c3d4",
                     lat, e, mem_word(8'h50));
        end
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("[TB] FAIL rd_wr_overlap: cycles=%0d expected 0", both_cnt);
        end
    endtask

    // Sequence the scenarios and report
    initial begin
        checks   = 0;
        failures = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        both_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
        end
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_extension();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit sitting directly upstream of the 256x8 big-endian data memory, between the datapath's ALU/register stage and DMEM.
- Accepts byte, halfword and word load/store requests and drives DMEM's word-only interface (MemRead, MemWrite, Address, WriteData). Consumes DMEM's combinational ReadData.
- Sub-word stores use a read-modify-write sequence; loads perform lane extraction with sign/zero extension.
- Issues a one-cycle completion handshake back to the datapath.

Parameters:
- ADDR_W, 8: byte address width; must match the DMEM Address width.
- DATA_W, 32: word width; fixed at 32 and not otherwise supported.

Ports:
- clk  in  1  rising-edge clock, shared with DMEM
- reset_n  in  1  synchronous reset, active-low
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1=store, 0=load
- size  in  2  00=byte, 01=halfword, 10=word, 11=reserved
- sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified for sub-word sizes
- busy  out  1  transaction in flight; new req is ignored while high
- done  out  1  one-cycle pulse when a transaction completes
- err  out  1  valid with done; misaligned access or size=11
- rdata  out  32  load result; holds its value until the next load completes
- dm_memread  out  1  to DMEM MemRead
- dm_memwrite  out  1  to DMEM MemWrite
- dm_address  out  ADDR_W  to DMEM Address; always word-aligned
- dm_writedata  out  32  to DMEM WriteData
- dm_readdata  in  32  from DMEM ReadData (combinational)

Behaviour:
Reset:
- Reset is synchronous, active-low (reset_n), on clk.
- While reset_n=0 at a rising edge: state goes to IDLE; busy, done, err = 0; rdata = 0.
- dm_* outputs are decoded from state, so they read 0 from the following cycle.
- A DMEM write whose WR cycle coincides with the reset edge still commits, because DMEM has no reset.

State machine (IDLE, RD, WR, DONE):
- IDLE: on req=1, latch we, size, sign_ext, addr and wdata; set busy=1. Next state:
  - DONE with err=1 if the access is illegal:
    - size=11, or
    - halfword with addr[0]≠0, or
    - word with addr[1:0]≠0.
    - Illegal accesses make no memory access.
  - WR for a legal word store.
  - RD for any other legal access.
- RD: dm_memread=1, dm_address={addr[7:2],2'b00}. At the end of the cycle, capture dm_readdata into the line buffer. Next state is DONE for a load, WR for a sub-word store.
- WR: dm_memwrite=1, dm_address=base. dm_writedata is one of:
  - wdata, for a word store;
  - the line buffer with the target lane replaced, for a sub-word store.
  - Next state is DONE.
- DONE: done=1 for exactly one cycle. For a load, rdata updates at the DONE entry edge. err is cleared on the next accept. Next state is IDLE with busy=0.
- req is not sampled in DONE, so back-to-back requests have a 1-cycle gap.

Outputs outside active states:
- dm_memread and dm_memwrite are never high together.
- dm_address and dm_writedata are 0 outside RD/WR.

Byte lanes (big-endian, matching DMEM):
- Byte offsets 0, 1, 2, 3 map to bits [31:24], [23:16], [15:8], [7:0].
- Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
- Store data is taken from wdata[7:0] (byte) or wdata[15:0] (halfword).

Load extension:
- Byte: bits [31:8] are all copies of the lane's bit 7 when sign_ext=1, else 0.
- Halfword: bits [31:16] are all copies of the lane's bit 15 when sign_ext=1, else 0.

Latency (edges after the accept edge until done is high):
- Illegal access: 1
- Load: 2
- Word store: 2
- Sub-word store: 3

Address wrap: the base address is always ≤252, so DMEM never indexes beyond byte 255.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=10. done is high 2 cycles after accept, with one WR cycle and no RD cycle. Then load word 0x10: rdata=0xDEADBEEF, err=0.
- Byte store RMW: preload 0x20=0x11223344, then store byte addr=0x22, wdata=0xAB. Sequence is RD, WR, DONE. DMEM word becomes 0x1122AB44. Load word 0x20 reads 0x1122AB44.
- Sign/zero extension: word 0x30=0x80FF7F01.
  - Load byte addr=0x31, sign_ext=1: 0xFFFFFFFF.
  - Load byte addr=0x32, sign_ext=1: 0x0000007F.
  - Load half addr=0x30, sign_ext=0: 0x000080FF.
  - Load half addr=0x30, sign_ext=1: 0xFFFF80FF.
- Illegal accesses: each must give done with err=1, 1 cycle after accept, with no dm_memread/dm_memwrite pulse and memory unchanged.
  - Word store addr=0x13.
  - Half load addr=0x41.
  - size=11 at addr=0x00.
- Busy and top address: hold req=1 with varying addr during an operation; only the first request is executed, and the next request is accepted only after done. A word store and load at addr=0xFC returns the value stored.
- Reset mid-operation: assert reset_n=0 during RD of a byte store. At the next edge busy=0 and done=0; no WR cycle occurs and memory is unchanged. A new request afterwards completes normally.
